// File: rtl/skew_delay_bank.sv
// skew_delay_bank: CHANNELS independent lanes, each a {valid,data} shift register
// tapped at a runtime-programmable depth, with optional systolic skew (lane k
// gets k extra stages). Feeds skewed operand rows/columns into the MAC array.
module skew_delay_bank #(
   parameter int CHANNELS    = 8,
   parameter int BITS        = 8,
   parameter int MAX_DEPTH   = 16,
   parameter int RESET_DEPTH = 8,
   parameter bit RESET_SKEW  = 1'b1,
   localparam int DW         = $clog2(MAX_DEPTH + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic                     clr,
   input  logic                     cfg_we,
   input  logic [DW-1:0]            cfg_depth,
   input  logic                     cfg_skew,
   input  logic [CHANNELS*BITS-1:0] d,
   input  logic [CHANNELS-1:0]      in_valid,
   output logic [CHANNELS*BITS-1:0] q,
   output logic [CHANNELS-1:0]      out_valid,
   output logic                     empty,
   output logic [DW-1:0]            depth,
   output logic                     skew
);

   // Every lane is sized for the deepest tap: max base depth plus max skew.
   localparam int L  = MAX_DEPTH + CHANNELS - 1;
   localparam int AW = (L > 1) ? $clog2(L) : 1;

   // Entry layout: bit BITS is the valid flag, bits BITS-1:0 the data.
   logic [BITS:0]   sr_r      [CHANNELS][L];
   logic [DW-1:0]   depth_r;
   logic            skew_r;
   logic [AW-1:0]   tap_idx_s [CHANNELS];
   logic            any_valid_s;

   // Requested depth is forced into the legal range 1..MAX_DEPTH.
   function automatic logic [DW-1:0] clamp_depth(input logic [DW-1:0] req);
      logic [DW-1:0] res;
      if (req == {DW{1'b0}}) begin
         res = DW'(1);
      end else if (int'(req) > MAX_DEPTH) begin
         res = DW'(MAX_DEPTH);
      end else begin
         res = req;
      end
      return res;
   endfunction

   // Lane storage: clear wins over shift; all lanes advance together on en.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < CHANNELS; k++) begin
            for (int i = 0; i < L; i++) begin
               sr_r[k][i] <= '0;
            end
         end
      end else if (clr) begin
         for (int k = 0; k < CHANNELS; k++) begin
            for (int i = 0; i < L; i++) begin
               sr_r[k][i] <= '0;
            end
         end
      end else if (en) begin
         for (int k = 0; k < CHANNELS; k++) begin
            sr_r[k][0] <= {in_valid[k], d[k*BITS +: BITS]};
            for (int i = 1; i < L; i++) begin
               sr_r[k][i] <= sr_r[k][i-1];
            end
         end
      end else begin
         for (int k = 0; k < CHANNELS; k++) begin
            for (int i = 0; i < L; i++) begin
               sr_r[k][i] <= sr_r[k][i];
            end
         end
      end
   end

   // Config registers: loaded independently of clr/en, never touched by clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         depth_r <= DW'(RESET_DEPTH);
         skew_r  <= RESET_SKEW;
      end else if (cfg_we) begin
         depth_r <= clamp_depth(cfg_depth);
         skew_r  <= cfg_skew;
      end else begin
         depth_r <= depth_r;
         skew_r  <= skew_r;
      end
   end

   // Tap position per lane: depth-1, plus the lane number when skewing.
   always_comb begin
      for (int k = 0; k < CHANNELS; k++) begin
         tap_idx_s[k] = '0;
         if (skew_r) begin
            tap_idx_s[k] = AW'(int'(depth_r) + k - 1);
         end else begin
            tap_idx_s[k] = AW'(int'(depth_r) - 1);
         end
      end
   end

   // Output taps read only registered state, so no input reaches an output.
   always_comb begin
      q         = '0;
      out_valid = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         q[k*BITS +: BITS] = sr_r[k][tap_idx_s[k]][BITS-1:0];
         out_valid[k]      = sr_r[k][tap_idx_s[k]][BITS];
      end
   end

   // Empty looks at every stored entry, including those beyond the active taps.
   always_comb begin
      any_valid_s = 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
         for (int i = 0; i < L; i++) begin
            any_valid_s = any_valid_s | sr_r[k][i][BITS];
         end
      end
   end

   assign empty = ~any_valid_s;
   assign depth = depth_r;
   assign skew  = skew_r;

endmodule

// File: tb/tb_skew_delay_bank.sv
// Testbench for skew_delay_bank: history-queue reference model checked every
// cycle, plus directed literal checks from the test plan.
module tb_skew_delay_bank;

   localparam int CH  = 8;
   localparam int B   = 8;
   localparam int MD  = 16;
   localparam int L   = MD + CH - 1;
   localparam int DW  = $clog2(MD + 1);

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            en = 1'b0, clr = 1'b0, cfg_we = 1'b0, cfg_skew = 1'b0;
   logic [DW-1:0]   cfg_depth = '0;
   logic [CH*B-1:0] d = '0;
   logic [CH-1:0]   in_valid = '0;
   logic [CH*B-1:0] q;
   logic [CH-1:0]   out_valid;
   logic            empty;
   logic [DW-1:0]   depth;
   logic            skew;

   int compared = 0;
   int mismatched = 0;

   skew_delay_bank #(.CHANNELS(CH), .BITS(B), .MAX_DEPTH(MD),
                     .RESET_DEPTH(8), .RESET_SKEW(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .cfg_we(cfg_we),
      .cfg_depth(cfg_depth), .cfg_skew(cfg_skew), .d(d), .in_valid(in_valid),
      .q(q), .out_valid(out_valid), .empty(empty), .depth(depth), .skew(skew));

   always #5 clk = ~clk;

   // Reference model: queue of accepted samples, newest first.
   typedef struct { logic [CH-1:0] v; logic [CH*B-1:0] dat; } samp_t;
   samp_t hist[$];
   int    m_depth = 8;
   bit    m_skew  = 1'b1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist.delete();
         m_depth = 8;
         m_skew  = 1'b1;
      end else begin
         if (cfg_we) begin
            m_depth = (cfg_depth == 0) ? 1 : ((int'(cfg_depth) > MD) ? MD : int'(cfg_depth));
            m_skew  = cfg_skew;
         end
         if (clr) begin
            hist.delete();
         end else if (en) begin
            samp_t s;
            s.v = in_valid;
            s.dat = d;
            hist.push_front(s);
            if (hist.size() > L) void'(hist.pop_back());
         end
      end
   end

   function automatic void model_out(output logic [CH*B-1:0] eq, output logic [CH-1:0] ev,
                                     output logic ee);
      eq = '0; ev = '0; ee = 1'b1;
      for (int k = 0; k < CH; k++) begin
         int dl = m_depth + (m_skew ? k : 0);
         if (hist.size() >= dl) begin
            eq[k*B +: B] = hist[dl-1].dat[k*B +: B];
            ev[k]        = hist[dl-1].v[k];
         end
      end
      foreach (hist[i]) if (hist[i].v != '0) ee = 1'b0;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      logic [CH*B-1:0] eq;
      logic [CH-1:0]   ev;
      logic            ee;
      model_out(eq, ev, ee);
      chk("q", 64'(q), 64'(eq));
      chk("out_valid", 64'(out_valid), 64'(ev));
      chk("empty", 64'(empty), 64'(ee));
      chk("depth", 64'(depth), 64'(m_depth));
      chk("skew", 64'(skew), 64'(m_skew));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      en = 1'b0; clr = 1'b0; cfg_we = 1'b0; in_valid = '0; d = '0;
   endtask

   task automatic cfg(input logic [DW-1:0] dep, input logic sk);
      idle();
      cfg_we = 1'b1; cfg_depth = dep; cfg_skew = sk; clr = 1'b1;
      tick();
      idle();
   endtask

   logic [CH*B-1:0] pat;

   initial begin
      // Reset
      #12;
      chk("rst_q", 64'(q), 64'd0);
      chk("rst_ov", 64'(out_valid), 64'd0);
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_depth", 64'(depth), 64'd8);
      chk("rst_skew", 64'(skew), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Basic delay with reset defaults (depth 8, skew 1)
      for (int k = 0; k < CH; k++) pat[k*B +: B] = 8'h10 + 8'(k);
      en = 1'b1; d = pat; in_valid = '1;
      tick();
      d = '0; in_valid = '0;
      for (int n = 2; n <= 24; n++) begin
         tick();
         if (n == 7)  chk("lane0_early", 64'(out_valid[0]), 64'd0);
         if (n == 8)  chk("lane0_n8", 64'({out_valid[0], q[7:0]}), 64'h110);
         if (n == 14) chk("lane7_early", 64'(out_valid[7]), 64'd0);
         if (n == 15) chk("lane7_n15", 64'({out_valid[7], q[63:56]}), 64'h117);
         if (n == 23) chk("empty_n23", 64'(empty), 64'd0);
         if (n == 24) chk("empty_n24", 64'(empty), 64'd1);
      end

      // No skew, depth 1: counter stream
      cfg(5'd1, 1'b0);
      for (int v = 1; v <= 10; v++) begin
         en = 1'b1; in_valid = '1;
         for (int k = 0; k < CH; k++) d[k*B +: B] = 8'(v + k);
         tick();
         if (v == 5) chk("d1_lane3", 64'({out_valid[3], q[31:24]}), 64'h108);
      end
      idle();
      tick();

      // Clamping
      cfg(5'd0, 1'b1);
      chk("clamp_lo", 64'(depth), 64'd1);
      cfg(5'd31, 1'b1);
      chk("clamp_hi", 64'(depth), 64'd16);
      en = 1'b1; in_valid = 8'h80; d = {8'h5C, 56'd0};
      tick();
      in_valid = '0; d = '0;
      for (int n = 2; n <= 23; n++) begin
         tick();
         if (n == 22) chk("lat23_early", 64'(out_valid[7]), 64'd0);
         if (n == 23) chk("lat23", 64'({out_valid[7], q[63:56]}), 64'h15C);
      end

      // en gaps with depth 4, skew 0
      cfg(5'd4, 1'b0);
      en = 1'b1; in_valid = 8'h01; d = 64'h3C;
      tick();
      in_valid = '0; d = '0;
      tick();
      en = 1'b0;
      repeat (3) tick();
      en = 1'b1;
      tick();
      chk("gap_early", 64'(out_valid[0]), 64'd0);
      tick();
      chk("gap_4th", 64'({out_valid[0], q[7:0]}), 64'h13C);
      idle();

      // clr over en
      for (int n = 0; n < 6; n++) begin
         en = 1'b1; in_valid = '1; d = {$urandom, $urandom};
         tick();
      end
      clr = 1'b1; en = 1'b1; d = {CH{8'hAA}}; in_valid = '1;
      tick();
      idle();
      chk("clr_q", 64'(q), 64'd0);
      chk("clr_ov", 64'(out_valid), 64'd0);
      chk("clr_empty", 64'(empty), 64'd1);
      chk("clr_cfg", 64'({skew, depth}), 64'h04);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         en       = ($urandom_range(0, 3) != 0);
         clr      = ($urandom_range(0, 99) == 0);
         cfg_we   = ($urandom_range(0, 39) == 0);
         cfg_depth = DW'($urandom_range(0, 31));
         cfg_skew = 1'($urandom);
         in_valid = CH'($urandom);
         d        = {$urandom, $urandom};
         tick();
      end
      cfg_we = 1'b0; clr = 1'b0;

      // Async reset mid-stream
      en = 1'b1; in_valid = '1; d = {$urandom, $urandom};
      cfg_we = 1'b1; cfg_depth = 5'd2; cfg_skew = 1'b0;
      tick();
      cfg_we = 1'b0;
      repeat (3) tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_q", 64'(q), 64'd0);
      chk("arst_ov", 64'(out_valid), 64'd0);
      chk("arst_empty", 64'(empty), 64'd1);
      chk("arst_depth", 64'(depth), 64'd8);
      chk("arst_skew", 64'(skew), 64'd1);
      tick();
      rst_n = 1'b1;
      idle();
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
